speaker_control: RTL and testbench

Serializes the 16-bit stereo sample pair produced by the tone/audio generators (`audio_left`, `audio_right`) into an I2S stream for the on-board audio DAC. Generates the DAC master clock, bit clock and word-select clock by dividing the system clock. Captures one stereo pair per frame at a fixed frame boundary and shifts it out MSB-first. Sits between the audio sample sources and the DAC pins at the top level.

---
 rtl/audio_pkg.sv | 21 ++
 rtl/speaker_control.sv | 98 +++++++++
 tb/tb_speaker_control.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// ---------------------------------------------------------------------------
// audio_pkg
// Shared constants for the audio path (speaker_control and the tone
// generators). One frame is 2^FRAME_W system clocks. Each channel gets
// SLOTS_PER_CH bit-clock slots. The *_BIT constants name the frame-counter
// bits that drive the DAC clock pins.
// ---------------------------------------------------------------------------
package audio_pkg;
    localparam int FRAME_W      = 10;
    localparam int SAMPLE_W     = 16;
    localparam int SLOTS_PER_CH = 32;

    // Frame-counter bit positions used directly as DAC clocks.
    localparam int MCLK_BIT     = 1;   // clk/4
    localparam int SCK_BIT      = 3;   // clk/16
    localparam int LRCK_BIT     = 9;   // clk/1024

    // The slot index sits just above the bit-clock bit.
    localparam int SLOT_LSB     = SCK_BIT + 1;
    localparam int SLOT_W       = $clog2(SLOTS_PER_CH);
endpackage

// File: rtl/speaker_control.sv
// ---------------------------------------------------------------------------
// speaker_control
// I2S serializer for the on-board audio DAC. A free-running frame counter
// produces MCLK, SCK and LRCK straight from its register bits. One stereo
// pair is captured at the end of every frame and shifted out MSB first in
// the following frame. The data is delayed by one bit slot after each LRCK
// edge (standard I2S).
//
// Ports
//   clk          in   system clock
//   rst_n        in   synchronous, active-low reset
//   audio_left   in   left sample (two's complement)
//   audio_right  in   right sample (two's complement)
//   audio_mclk   out  DAC master clock, clk/4
//   audio_sck    out  I2S bit clock, clk/16
//   audio_lrck   out  word select, clk/1024 (0 = left, 1 = right)
//   audio_sdin   out  I2S serial data
//   sample_tick  out  one-cycle pulse on the cycle the input pair is captured
// ---------------------------------------------------------------------------
module speaker_control
    import audio_pkg::*;
#(
    parameter int CNT_W = FRAME_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] audio_left,
    input  logic [SAMPLE_W-1:0] audio_right,
    output logic                audio_mclk,
    output logic                audio_sck,
    output logic                audio_lrck,
    output logic                audio_sdin,
    output logic                sample_tick
);

    logic [CNT_W-1:0]    r_cnt;
    logic [SAMPLE_W-1:0] r_hold_l;
    logic [SAMPLE_W-1:0] r_hold_r;
    logic                r_sdin;
    logic                r_tick;

    logic [CNT_W-1:0]    w_cnt_next;
    logic [SLOT_W-1:0]   w_slot_next;
    logic [SAMPLE_W-1:0] w_hold_next;
    logic [3:0]          w_bit_idx;
    logic                w_data_slot;
    logic                w_capture;
    logic                w_sdin_next;

    assign w_cnt_next  = r_cnt + CNT_W'(1);
    assign w_capture   = (r_cnt == '1);

    // audio_sdin is registered from the *next* counter value. It therefore
    // changes on the SCK falling edge and is stable at the SCK rising edge.
    // The holds only change on the 1023->0 edge. That edge lands in slot 0,
    // which always sends 0, so the holds never change while a data bit is
    // being loaded from them.
    assign w_slot_next = w_cnt_next[SLOT_LSB +: SLOT_W];
    assign w_hold_next = w_cnt_next[LRCK_BIT] ? r_hold_r : r_hold_l;
    assign w_data_slot = (w_slot_next != '0) && (w_slot_next <= SLOT_W'(SAMPLE_W));
    // Slot k carries bit 16-k, so slot 1 carries the MSB.
    assign w_bit_idx   = 4'(SLOT_W'(SAMPLE_W) - w_slot_next);

    always_comb begin
        w_sdin_next = 1'b0;
        if (w_data_slot) begin
            w_sdin_next = w_hold_next[w_bit_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_hold_l <= '0;
            r_hold_r <= '0;
            r_sdin   <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_cnt  <= w_cnt_next;
            r_sdin <= w_sdin_next;
            // The tick is registered so that it is high exactly while
            // r_cnt == 1023, which is the cycle whose closing edge captures
            // the inputs.
            r_tick <= (w_cnt_next == '1);
            if (w_capture) begin
                r_hold_l <= audio_left;
                r_hold_r <= audio_right;
            end
        end
    end

    assign audio_mclk  = r_cnt[MCLK_BIT];
    assign audio_sck   = r_cnt[SCK_BIT];
    assign audio_lrck  = r_cnt[LRCK_BIT];
    assign audio_sdin  = r_sdin;
    assign sample_tick = r_tick;

endmodule

// File: tb/tb_speaker_control.sv
// ---------------------------------------------------------------------------
// tb_speaker_control
// Randomised bench for the I2S serializer. A frame-level reference model
// tracks the frame position from reset. At each capture edge it queues the
// stereo pair expected in the next frame. A monitor collects the 64 slot bits
// seen at SCK rising edges, rebuilds the left/right words, and compares them
// against the queued pair. Clock pins, sample_tick and the sdin transition
// alignment are checked every cycle from their periods.
// ---------------------------------------------------------------------------
module tb_speaker_control;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] audio_left = '0;
  logic [15:0] audio_right = '0;
  logic        audio_mclk;
  logic        audio_sck;
  logic        audio_lrck;
  logic        audio_sdin;
  logic        sample_tick;

  speaker_control #(.CNT_W(10)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .audio_left  (audio_left),
    .audio_right (audio_right),
    .audio_mclk  (audio_mclk),
    .audio_sck   (audio_sck),
    .audio_lrck  (audio_lrck),
    .audio_sdin  (audio_sdin),
    .sample_tick (sample_tick)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / scoreboard state ----------------
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];        // {left, right} expected per frame

  int          m_pos = 0;       // frame position of the DUT after the last edge
  bit          m_rst = 1'b1;    // last edge was a reset edge
  bit          m_live = 1'b0;
  longint      m_cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (frame pos %0d)", name, act, exp, m_pos);
    end
  endtask

  // ---------------- reference model ----------------
  // One frame = 1024 clocks. A reset restarts the frame with empty (zero)
  // holds. The pair standing at the last edge of a frame is what the next
  // frame sends.
  always @(posedge clk) begin
    m_live = 1'b1;
    m_cyc++;
    if (!rst_n) begin
      m_rst = 1'b1;
      m_pos = 0;
      exp_q.delete();
      exp_q.push_back(32'h0);
    end else begin
      m_rst = 1'b0;
      if (m_pos == 1023) exp_q.push_back({audio_left, audio_right});
      m_pos = (m_pos + 1) % 1024;
    end
  end

  // ---------------- monitor ----------------
  bit          slot_bits[64];
  bit          coll_ok = 1'b0;
  logic        prev_sdin;
  bit          have_tick = 1'b0;
  longint      last_tick = 0;
  int          tick_count = 0;
  int          c;
  logic [15:0] got_l;
  logic [15:0] got_r;
  int          pad_ones;
  logic [31:0] exp_pair;

  always @(negedge clk) begin
    if (m_live) begin
      c = m_pos;
      if (m_rst) begin
        check("reset_outputs", {audio_mclk, audio_sck, audio_lrck, audio_sdin, sample_tick}, 5'b0);
        coll_ok = 1'b0;
        have_tick = 1'b0;
      end else begin
        check("mclk", audio_mclk, (c % 4) >= 2);
        check("sck", audio_sck, (c % 16) >= 8);
        check("lrck", audio_lrck, c >= 512);
        check("sample_tick", sample_tick, c == 1023);
        if (sample_tick === 1'b1) begin
          if (have_tick) check("tick_spacing", m_cyc - last_tick, 64'd1024);
          last_tick = m_cyc;
          have_tick = 1'b1;
          tick_count++;
        end
        if (audio_sdin !== prev_sdin) check("sdin_edge_align", c % 16, 0);
        if (c % 16 == 8) begin
          slot_bits[c / 16] = audio_sdin;
          if (c == 8) coll_ok = 1'b1;
        end
        if (c == 1016 && coll_ok) begin
          got_l = '0;
          got_r = '0;
          pad_ones = 0;
          for (int s = 0; s < 64; s++) begin
            if (s >= 1 && s <= 16) got_l[16 - s] = slot_bits[s];
            else if (s >= 33 && s <= 48) got_r[48 - s] = slot_bits[s];
            else pad_ones += int'(slot_bits[s]);
          end
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL frame_queue: got empty queue expected one pending frame");
          end else begin
            exp_pair = exp_q.pop_front();
            check("frame_left", got_l, exp_pair[31:16]);
            check("frame_right", got_r, exp_pair[15:0]);
            check("frame_pad_zero", pad_ones, 0);
          end
        end
      end
      prev_sdin = audio_sdin;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_pos(input int target);
    for (int k = 0; k < 2100; k++) begin
      @(negedge clk);
      if (!m_rst && m_pos == target) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL wait_pos: got timeout expected frame pos %0d", target);
  endtask

  task automatic drive_pair(input logic [15:0] l, input logic [15:0] r);
    audio_left = l;
    audio_right = r;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    drive_pair(16'hA5A5, 16'h8001);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Frame 0 sends zeros; frame 1 sends A5A5 / 8001.
    wait_pos(1023);
    wait_pos(1023);

    // Left 0000 for frame 2, changed to FFFF mid-frame: only frame 3 sees it.
    drive_pair(16'h0000, 16'h8001);
    wait_pos(600);
    drive_pair(16'hFFFF, 16'h8001);
    wait_pos(1023);

    // Random pairs, changed mid-frame and again on the capture cycle itself.
    for (int i = 0; i < 5; i++) begin
      wait_pos($urandom_range(100, 1000));
      drive_pair(16'($urandom), 16'($urandom));
      wait_pos(1023);
      drive_pair(16'($urandom), 16'($urandom));
    end

    // One-cycle reset during a right-channel word.
    wait_pos(700);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    drive_pair(16'($urandom), 16'($urandom));

    wait_pos(1023);
    wait_pos(1023);
    wait_pos(1017);

    check("tick_count_nonzero", tick_count > 0, 1'b1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
